note_player: RTL
================

NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter NOTE_CYCLES, default 50_000_000, number of clock cycles each note sounds.
REQ-003 SHALL have parameter GAP_CYCLES, default 5_000_000, number of silent clock cycles after each note; 0 is legal.
REQ-004 SHALL have ports: clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have ports: rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have ports: note_in  input  4  note code (0 = rest, 1..7 = do..si, 8..15 = treated as rest).
REQ-007 SHALL have ports: note_valid  input  1  note_in is offered.
REQ-008 SHALL have ports: note_ready  output  1  block accepts a note this cycle.
REQ-009 SHALL have ports: abort  input  1  terminate the current note/gap.
REQ-010 SHALL have ports: speaker  output  1  square-wave buzzer drive.
REQ-011 SHALL have ports: led_out  output  7  one-hot of the sounding note (bit n-1 for code n).
REQ-012 SHALL have ports: busy  output  1  high in PLAY or GAP.

Function
REQ-013 SHALL implement FSM states IDLE, PLAY, GAP.
REQ-014 SHALL drive note_ready = 1 only in IDLE, and busy = 1 only in PLAY or GAP.
REQ-015 SHALL accept a note when note_valid & note_ready; it SHALL latch note_in and enter PLAY on the next cycle.
REQ-016 SHALL ignore note_valid outside IDLE; a held note is not lost, it is accepted on the first IDLE cycle.
REQ-017 SHALL hold PLAY for exactly NOTE_CYCLES cycles, then enter GAP; if GAP_CYCLES = 0 it SHALL enter IDLE instead.
REQ-018 SHALL hold GAP for exactly GAP_CYCLES cycles, then enter IDLE.
REQ-019 In PLAY with code 1..7:
- half-period HP = floor(CLK_HZ / (2*freq)), freq from the table 262, 294, 330, 349, 392, 440, 494 Hz.
- speaker starts at 0 on PLAY entry and toggles every HP cycles.
REQ-020 In PLAY with code 0 or 8..15: speaker = 0 and led_out = 0 for the full note duration.
REQ-021 SHALL hold speaker = 0 and led_out = 0 in IDLE and GAP.
REQ-022 In PLAY, led_out SHALL be the one-hot of the latched code for the whole of PLAY.
REQ-023 abort SHALL force IDLE on the next cycle from any state: counters cleared, speaker = 0, led_out = 0.
REQ-024 If abort and note_valid are both high in IDLE, abort wins and no note is accepted.
REQ-025 Duration and tone counters SHALL be sized to hold NOTE_CYCLES, GAP_CYCLES and the largest HP without overflow.
REQ-026 The tone counter SHALL restart at 0 on every PLAY entry; no phase carries over between notes.

Reset
REQ-027 On rst, SHALL enter IDLE with note_ready = 1, busy = 0, speaker = 0, led_out = 0, latched note = 0 and all counters = 0.
REQ-028 rst SHALL take priority over abort and over the handshake, including mid-note.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef, the note-code constants 0..7 and the 7-entry frequency table.
REQ-030 Sub-module tone_gen SHALL take HP and an enable and produce the square wave; the FSM and counters SHALL stay in note_player.

Verification
Bench parameters: CLK_HZ = 8800, NOTE_CYCLES = 40, GAP_CYCLES = 4.
REQ-031 Send code 6 -> speaker toggles every 10 cycles for 40 cycles, led_out = 7'b0100000, then 4 silent cycles, then note_ready = 1.
REQ-032 Send code 1 -> HP = 16, led_out = 7'b0000001; send code 0 -> 40 silent cycles with led_out = 0, busy = 1.
REQ-033 Hold note_valid high with codes 3 then 5 back to back -> each note is played exactly once, in order, with a 4-cycle gap between them.
REQ-034 Assert abort at PLAY cycle 15 -> next cycle IDLE, speaker = 0, led_out = 0, note_ready = 1.
REQ-035 Assert rst mid-GAP -> all outputs at their reset values next cycle; a following code 7 plays with HP = 8.
REQ-036 Set GAP_CYCLES = 0 and send code 12 -> 40 silent cycles with led_out = 0, then IDLE directly.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared types, note codes and tone table for the note player.
package note_player_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  // Tone frequencies in Hz for codes do..si.
  localparam int FREQ_TAB [7] = '{262, 294, 330, 349, 392, 440, 494};

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Codes outside do..si light nothing.
  function automatic logic [6:0] note_onehot(input logic [3:0] code);
    note_onehot = '0;
    if (code != NOTE_REST && code <= NOTE_SI) note_onehot[code[2:0] - 3'd1] = 1'b1;
  endfunction

endpackage

// File: rtl/note_player_tone_gen.sv
// Square-wave generator: toggles its output every hp enabled cycles, starting low.
module tone_gen #(
  parameter int HPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           en,
  input  logic [HPW-1:0] hp,
  output logic           wave
);

  logic [HPW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (en && hp != '0) begin
      if (cnt == hp - 1'b1) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_player.sv
// Plays one note per handshake: NOTE_CYCLES of tone, GAP_CYCLES of silence, then ready again.
module note_player
  import note_player_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int NOTE_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] note_in,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic       abort,
  output logic       speaker,
  output logic [6:0] led_out,
  output logic       busy
);

  localparam int DW  = $clog2(max2(NOTE_CYCLES, GAP_CYCLES) + 1);
  // Lowest note has the longest half period, so it sizes the tone counter.
  localparam int HPW = $clog2(CLK_HZ / (2 * FREQ_TAB[0]) + 1);

  state_t         state;
  logic [3:0]     note_q;
  logic [DW-1:0]  dur;
  logic [HPW-1:0] hp_tab [8];
  logic [HPW-1:0] hp;
  logic           play_last;

  assign hp_tab[0] = '0;
  for (genvar i = 1; i < 8; i++) begin : g_hp
    assign hp_tab[i] = HPW'(CLK_HZ / (2 * FREQ_TAB[i-1]));
  end

  assign hp         = note_q[3] ? '0 : hp_tab[note_q[2:0]];
  assign play_last  = (state == PLAY) && (dur == DW'(NOTE_CYCLES - 1));
  assign note_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      note_q  <= '0;
      dur     <= '0;
      led_out <= '0;
    end else if (abort) begin
      state   <= IDLE;
      dur     <= '0;
      led_out <= '0;
    end else begin
      case (state)
        IDLE: if (note_valid) begin
          note_q  <= note_in;
          dur     <= '0;
          led_out <= note_onehot(note_in);
          state   <= PLAY;
        end
        PLAY: if (play_last) begin
          dur     <= '0;
          led_out <= '0;
          state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          dur <= dur + 1'b1;
        end
        GAP: if (dur == DW'(GAP_CYCLES - 1)) begin
          dur   <= '0;
          state <= IDLE;
        end else begin
          dur <= dur + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Held clear outside PLAY and on the last PLAY edge so every note starts low at phase 0.
  tone_gen #(.HPW(HPW)) u_tone (
    .clk   (clk),
    .rst   (rst),
    .clear (abort || (state != PLAY) || play_last),
    .en    ((state == PLAY) && (led_out != '0)),
    .hp    (hp),
    .wave  (speaker)
  );

endmodule
